i2c_write_master: RTL and testbench

Byte-level I2C write master that executes the camera register-programming transactions. The configuration sequencer presents the 7-bit slave address and a byte stream through a ready/transmit/ack/nack handshake. The master generates START, the address byte with the write bit, the data bytes, per-byte ACK sampling and STOP on the open-drain SDA/SCL pins. It is the stage directly below the camera setup FSM and above the physical I2C pads.

---
 rtl/i2c_write_master.sv | 149 ++++++++++++++
 tb/tb_i2c_write_master.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/i2c_write_master.sv
// Byte-level I2C write master: START, address+W, data bytes with per-byte ACK check, STOP.
// Define I2C_STRETCH_EN for open-drain SCL with slave clock stretching.
module i2c_write_master #(
  parameter int unsigned CLK_DIV = 120
) (
  input  logic       iClock,
  input  logic       iReset,
  input  logic [6:0] iSlv_Addr,
  input  logic [7:0] iData,
  input  logic       iTransmit,
  output logic       oReady,
  output logic       oAck,
  output logic       oNack,
  inout  wire        I2C_SDA,
  inout  wire        I2C_SCL
);

  typedef enum logic [2:0] {IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP} state_t;

  state_t      state;
  logic [11:0] qcnt;
  logic [1:0]  quarter;
  logic [2:0]  bitcnt;
  logic [7:0]  shift;
  logic        sampled;
  logic        scl_q;
  logic        sda_low;
  logic        qend;
  logic        hold;
  logic [1:0]  last_q;

  // Pin levels for a given phase: {scl, sda_low}
  function automatic logic [1:0] pins(input state_t st, input logic [1:0] q, input logic b);
    pins = 2'b10;
    case (st)
      START:              pins = {(q == 2'd0), 1'b1};
      ADDR, DATA:         pins = {(q == 2'd1 || q == 2'd2), ~b};
      ADDR_ACK, DATA_ACK: pins = {(q == 2'd1 || q == 2'd2), 1'b0};
      STOP:               pins = {(q != 2'd0), (q != 2'd2)};
      default:            pins = 2'b10;
    endcase
  endfunction

  assign qend = (qcnt == 12'(CLK_DIV - 1));

  always_comb begin
    last_q = 2'd3;
    if (state == START)     last_q = 2'd1;
    else if (state == STOP) last_q = 2'd2;
  end

`ifdef I2C_STRETCH_EN
  assign hold = !I2C_SCL &&
                ((quarter == 2'd1 && (state == ADDR || state == ADDR_ACK ||
                                      state == DATA || state == DATA_ACK)) ||
                 (state == STOP && quarter != 2'd0));
  assign I2C_SCL = scl_q ? 1'bz : 1'b0;
`else
  assign hold = 1'b0;
  assign I2C_SCL = scl_q;
`endif

  assign I2C_SDA = sda_low ? 1'b0 : 1'bz;

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state   <= IDLE;
      qcnt    <= '0;
      quarter <= '0;
      bitcnt  <= '0;
      shift   <= '0;
      sampled <= 1'b0;
      scl_q   <= 1'b1;
      sda_low <= 1'b0;
      oReady  <= 1'b1;
      oAck    <= 1'b0;
      oNack   <= 1'b0;
    end else begin
      oAck  <= 1'b0;
      oNack <= 1'b0;
      if (state == IDLE) begin
        qcnt    <= '0;
        quarter <= '0;
        bitcnt  <= '0;
        if (iTransmit) begin
          state              <= START;
          shift              <= {iSlv_Addr, 1'b0};
          oReady             <= 1'b0;
          {scl_q, sda_low}   <= pins(START, 2'd0, 1'b0);
        end
      end else if (!hold) begin
        if (!qend) begin
          qcnt <= qcnt + 12'd1;
        end else begin
          qcnt <= '0;
          if (quarter == 2'd2 && (state == ADDR_ACK || state == DATA_ACK))
            sampled <= I2C_SDA;
          if (quarter != last_q) begin
            quarter          <= quarter + 2'd1;
            {scl_q, sda_low} <= pins(state, quarter + 2'd1, shift[7]);
          end else begin
            quarter <= '0;
            case (state)
              START: begin
                state            <= ADDR;
                bitcnt           <= '0;
                {scl_q, sda_low} <= pins(ADDR, 2'd0, shift[7]);
              end
              ADDR, DATA: begin
                if (bitcnt == 3'd7) begin
                  state            <= (state == ADDR) ? ADDR_ACK : DATA_ACK;
                  {scl_q, sda_low} <= pins(ADDR_ACK, 2'd0, 1'b0);
                end else begin
                  bitcnt           <= bitcnt + 3'd1;
                  shift            <= {shift[6:0], 1'b0};
                  {scl_q, sda_low} <= pins(state, 2'd0, shift[6]);
                end
              end
              ADDR_ACK, DATA_ACK: begin
                // the address ACK always continues: at least one data byte follows
                if (sampled) begin
                  oNack            <= 1'b1;
                  state            <= STOP;
                  {scl_q, sda_low} <= pins(STOP, 2'd0, 1'b0);
                end else if (state == ADDR_ACK || iTransmit) begin
                  shift            <= iData;
                  oAck             <= 1'b1;
                  bitcnt           <= '0;
                  state            <= DATA;
                  {scl_q, sda_low} <= pins(DATA, 2'd0, iData[7]);
                end else begin
                  state            <= STOP;
                  {scl_q, sda_low} <= pins(STOP, 2'd0, 1'b0);
                end
              end
              STOP: begin
                state            <= IDLE;
                oReady           <= 1'b1;
                {scl_q, sda_low} <= pins(IDLE, 2'd0, 1'b0);
              end
              default: state <= IDLE;
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_write_master.sv
// Scoreboard bench for i2c_write_master: a bus monitor/slave and an event monitor check
// against byte, event and timing expectations pushed by the sequencer-side driver.
module tb_i2c_write_master;

  localparam int unsigned D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx = 1'b0;
  logic [6:0] addr = '0;
  logic [7:0] data = '0;
  logic       ready, ack, nack;
  wire        sda, scl;
  logic       slave_low = 1'b0;
  logic       scl_hold = 1'b0;

  int          vectors = 0;
  int          miscompares = 0;
  int unsigned cyc = 0;
  logic [7:0]  exp_byte[$];
  bit          exp_evt[$];
  int          stop_seen = 0;
  int          exp_stops = 0;
  int          bitn = 0;
  int          byte_idx = 0;
  int          nack_at = -1;
  logic [7:0]  sh = '0;
  logic [7:0]  tx_d [4];

  i2c_write_master #(.CLK_DIV(D)) dut (
    .iClock(clk), .iReset(rst), .iSlv_Addr(addr), .iData(data), .iTransmit(tx),
    .oReady(ready), .oAck(ack), .oNack(nack), .I2C_SDA(sda), .I2C_SCL(scl)
  );

  pullup (sda);
  assign sda = slave_low ? 1'b0 : 1'bz;
`ifdef I2C_STRETCH_EN
  pullup (scl);
  assign scl = scl_hold ? 1'b0 : 1'bz;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bus monitor: START/STOP detection and byte decode on SCL rising edges
  always @(negedge sda) if (rst === 1'b0 && scl === 1'b1) begin bitn = 0; byte_idx = 0; end
  always @(posedge sda) if (rst === 1'b0 && scl === 1'b1) stop_seen++;
  always @(posedge scl) if (rst === 1'b0) begin
    if (bitn < 8) begin
      sh = {sh[6:0], sda};
      bitn++;
      if (bitn == 8) begin
        if (exp_byte.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL bus_byte: got %h, none expected", sh);
        end else check("bus_byte", sh, exp_byte.pop_front());
      end
    end else begin
      bitn = 0;
      byte_idx++;
    end
  end
  // Slave: ACK every byte except the planned NACK one
  always @(negedge scl) slave_low <= (rst === 1'b0) && (bitn == 8) && (byte_idx != nack_at);

  // Handshake event monitor
  always @(negedge clk) if (rst === 1'b0) begin
    if (ack === 1'b1 && nack === 1'b1) check("ack_nack_overlap", 32'(ack & nack), 0);
    if (ack === 1'b1 || nack === 1'b1) begin
      if (exp_evt.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL handshake_event: got ack=%b nack=%b, none expected", ack, nack);
      end else check(ack ? "ack_event" : "nack_event", 32'(nack), 32'(exp_evt.pop_front()));
    end
  end

  task automatic wait_ready();
    int unsigned t;
    t = 0;
    while (ready !== 1'b1 && t < 5000) begin @(negedge clk); t++; end
    if (t >= 5000) check("ready_timeout", 32'(ready), 1);
  endtask

  // na: index of the NACKed byte (0 = address, k = data byte k), -1 for none
  task automatic run_txn(input logic [6:0] a, input int unsigned n, input int na,
                         input int unsigned stretch);
    int unsigned acc, k, m, acks, t;
    bit nacked, first;
    nacked = (na >= 0) && (na <= int'(n));
    m      = nacked ? 32'(na) + 1 : n + 1;
    acks   = nacked ? 32'(na) : n;
    exp_byte.push_back({a, 1'b0});
    for (int unsigned i = 1; i < m; i++) exp_byte.push_back(tx_d[i-1]);
    for (int unsigned i = 0; i < acks; i++) exp_evt.push_back(1'b0);
    if (nacked) exp_evt.push_back(1'b1);
    exp_stops++;
    wait_ready();
    nack_at = na;
    addr = a; data = tx_d[0]; tx = 1'b1;
    acc = cyc + 1;
    k = 0; t = 0; first = 1'b1;
    do begin
      @(negedge clk); t++;
      if (first) begin
        check("start_sda_low", 32'(sda), 0);
        check("ready_low", 32'(ready), 0);
        first = 1'b0;
      end
      if (stretch != 0 && cyc == acc + 31*D - 1) scl_hold = 1'b1;
      if (cyc == acc + 31*D + stretch) scl_hold = 1'b0;
      if (ack === 1'b1) begin
        k++;
        if (k < n) data = tx_d[k];
        else tx = 1'b0;
      end
      if (nack === 1'b1) tx = 1'b0;
    end while (ready !== 1'b1 && t < 20000);
    if (t >= 20000) check("txn_timeout", 32'(ready), 1);
    else check("ready_cycle", cyc - acc + 1, (2 + 36*m + 3)*D + 1 + stretch);
    check("stop_count", stop_seen, exp_stops);
  endtask

  task automatic run_reset_txn(input logic [6:0] a);
    int unsigned acc, t;
    int stops_before;
    tx_d[0] = 8'($urandom) | 8'h10;  // data bit slot 3 releases SDA, so reset raises only SCL
    exp_byte.push_back({a, 1'b0});
    exp_evt.push_back(1'b0);
    wait_ready();
    nack_at = -1;
    addr = a; data = tx_d[0]; tx = 1'b1;
    acc = cyc + 1;
    t = 0;
    while (cyc != acc + 50*D && t < 1000) begin @(negedge clk); t++; end
    if (t >= 1000) check("reset_point_timeout", cyc, acc + 50*D);
    stops_before = stop_seen;
    rst = 1'b1; tx = 1'b0;
    @(negedge clk);
    check("rst_scl", 32'(scl), 1);
    check("rst_sda", 32'(sda), 1);
    check("rst_ready", 32'(ready), 1);
    check("rst_ack", 32'(ack), 0);
    check("rst_no_stop", stop_seen, stops_before);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_ready", 32'(ready), 1);
    check("reset_ack", 32'(ack), 0);
    check("reset_nack", 32'(nack), 0);
    check("reset_scl", 32'(scl), 1);
    check("reset_sda", 32'(sda), 1);
    rst = 1'b0;
    @(negedge clk);

    tx_d[0] = 8'h12; tx_d[1] = 8'h80;
    run_txn(7'h21, 2, -1, 0);
    tx_d[0] = 8'($urandom);
    run_txn(7'h5A, 1, 0, 0);
    tx_d[0] = 8'h12; tx_d[1] = 8'h80;
    run_txn(7'h21, 2, 1, 0);
    tx_d[0] = 8'h12; tx_d[1] = 8'h80; tx_d[2] = 8'h3C;
    run_txn(7'h21, 3, -1, 0);
    run_reset_txn(7'h33);
`ifdef I2C_STRETCH_EN
    tx_d[0] = 8'h12; tx_d[1] = 8'h80;
    run_txn(7'h21, 2, -1, 50);
`endif
    for (int r = 0; r < 8; r++) begin
      int unsigned n;
      int pick;
      n = $urandom_range(1, 4);
      for (int i = 0; i < 4; i++) tx_d[i] = 8'($urandom);
      pick = int'($urandom_range(0, 7));
      run_txn(7'($urandom), n, (pick <= int'(n)) ? pick : -1, 0);
    end

    repeat (4 * D) @(negedge clk);
    check("bytes_left", exp_byte.size(), 0);
    check("events_left", exp_evt.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
